// File: rtl/addsub_ctrl_pkg.sv
// addsub_ctrl_pkg: shared state encoding and widths for addsub_step_ctrl
package addsub_ctrl_pkg;
  localparam int STATE_W = 2;
  localparam int DEF_WIDTH = 8;
  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 2'd0,
    S_GOT_A = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/addsub_step_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stable-count debouncer and rising-edge pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic rise_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic level_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
      level_d <= 1'b0;
    end else begin
      sync <= {sync[0], btn_raw};
      level_d <= level;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        level <= sync[1];
      end else cnt <= cnt + 1'b1;
    end
  end
  assign rise_pulse = level & ~level_d;
endmodule

// File: rtl/addsub_step_ctrl.sv
// addsub_step_ctrl: step-button operand entry FSM for the add/sub stage; ADDSUB_OVF_FLAG_EN enables ovf_q
module addsub_step_ctrl
  import addsub_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   sw_data,
  input  logic               sw_mode,
  input  logic               sw_cin,
  input  logic               btn_step,
  input  logic               clr,
  output logic [WIDTH-1:0]   op_a,
  output logic [WIDTH-1:0]   op_b,
  output logic               op_e,
  output logic               op_c0,
  input  logic [WIDTH-1:0]   res_in,
  input  logic               c_in,
  output logic [WIDTH-1:0]   result_q,
  output logic               carry_q,
  output logic               ovf_q,
  output logic               done,
  output logic [STATE_W-1:0] state_o
);
  state_t state, state_n;
  logic step;
  logic btn_level;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_step),
    .level(btn_level),
    .rise_pulse(step)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = clr ? S_IDLE :
              state == S_EXEC ? S_DONE :
              !step ? state :
              state == S_GOT_A ? S_EXEC : S_GOT_A;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
      op_e <= 1'b0;
      op_c0 <= 1'b0;
      result_q <= '0;
      carry_q <= 1'b0;
    end else if (clr) begin
      op_a <= '0;
      op_b <= '0;
      op_e <= 1'b0;
      op_c0 <= 1'b0;
      result_q <= '0;
      carry_q <= 1'b0;
    end else begin
      if (step && (state == S_IDLE || state == S_DONE)) op_a <= sw_data;
      if (step && state == S_GOT_A) begin
        op_b <= sw_data;
        op_e <= sw_mode;
        op_c0 <= sw_cin;
      end
      if (state == S_EXEC) begin
        result_q <= res_in;
        carry_q <= c_in;
      end
    end
  end
`ifdef ADDSUB_OVF_FLAG_EN
  logic ovf_r;
  logic ab_same, r_flip;
  assign ab_same = op_a[WIDTH-1] == op_b[WIDTH-1];
  assign r_flip = res_in[WIDTH-1] != op_a[WIDTH-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_r <= 1'b0;
    else if (clr) ovf_r <= 1'b0;
    else if (state == S_EXEC) ovf_r <= (op_e ? ab_same : !ab_same) && r_flip;
  end
  assign ovf_q = ovf_r;
`else
  assign ovf_q = 1'b0;
`endif
  assign done = state == S_DONE;
  assign state_o = state;
endmodule

// File: tb/tb_addsub_step_ctrl.sv
// tb_addsub_step_ctrl: table-driven and directed-sequence bench for addsub_step_ctrl
module tb_addsub_step_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] sw_data = '0;
  logic sw_mode = 1'b0;
  logic sw_cin = 1'b0;
  logic btn_step = 1'b0;
  logic clr = 1'b0;
  logic [7:0] op_a, op_b, res_in, result_q;
  logic op_e, op_c0, c_in, carry_q, ovf_q, done;
  logic [1:0] state_o;
  logic [8:0] stage;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic e;
    logic c0;
    logic [7:0] r;
    logic c;
    logic ovf;
  } vec_t;
  vec_t tv[7];
  always #5 clk = ~clk;
  assign stage = op_e ? {1'b0, op_a} + {1'b0, op_b} + 9'(op_c0)
                      : {1'b0, op_a} - {1'b0, op_b} - 9'(op_c0);
  assign res_in = stage[7:0];
  assign c_in = stage[8];
  addsub_step_ctrl #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw_data(sw_data),
    .sw_mode(sw_mode),
    .sw_cin(sw_cin),
    .btn_step(btn_step),
    .clr(clr),
    .op_a(op_a),
    .op_b(op_b),
    .op_e(op_e),
    .op_c0(op_c0),
    .res_in(res_in),
    .c_in(c_in),
    .result_q(result_q),
    .carry_q(carry_q),
    .ovf_q(ovf_q),
    .done(done),
    .state_o(state_o)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic press(input int hold, input int rel);
    btn_step = 1'b1;
    repeat (hold) @(negedge clk);
    btn_step = 1'b0;
    repeat (rel) @(negedge clk);
  endtask
  task automatic all_zero(input string tag);
    chk({tag, "_state"}, 32'(state_o), 0);
    chk({tag, "_op_a"}, 32'(op_a), 0);
    chk({tag, "_op_b"}, 32'(op_b), 0);
    chk({tag, "_op_ec"}, {30'd0, op_e, op_c0}, 0);
    chk({tag, "_result"}, 32'(result_q), 0);
    chk({tag, "_flags"}, {29'd0, carry_q, ovf_q, done}, 0);
  endtask
  task automatic do_op(input vec_t v);
    int n;
    sw_data = v.a;
    press(10, 10);
    chk("a_state", 32'(state_o), 1);
    chk("a_capture", 32'(op_a), 32'(v.a));
    chk("a_done_low", 32'(done), 0);
    sw_data = v.b;
    sw_mode = v.e;
    sw_cin = v.c0;
    btn_step = 1'b1;
    n = 0;
    while (state_o == 2'd1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("exec_state", 32'(state_o), 2);
    @(negedge clk);
    chk("done_state", 32'(state_o), 3);
    chk("done_flag", 32'(done), 1);
    btn_step = 1'b0;
    repeat (10) @(negedge clk);
    chk("b_capture", {22'd0, op_b, op_e, op_c0}, {22'd0, v.b, v.e, v.c0});
    chk("result", 32'(result_q), 32'(v.r));
    chk("carry", 32'(carry_q), 32'(v.c));
`ifdef ADDSUB_OVF_FLAG_EN
    chk("ovf", 32'(ovf_q), 32'(v.ovf));
`else
    chk("ovf", 32'(ovf_q), 0);
`endif
    chk("done_hold", 32'(state_o), 3);
  endtask
  initial begin
    tv[0] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tv[1] = '{8'h03, 8'h05, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0};
    tv[2] = '{8'h05, 8'h03, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0};
    tv[3] = '{8'h7F, 8'h01, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
    tv[4] = '{8'h10, 8'h20, 1'b1, 1'b1, 8'h31, 1'b0, 1'b0};
    tv[5] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0};
    tv[6] = '{8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1};
    repeat (3) @(negedge clk);
    all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", 32'(state_o), 0);
    for (int i = 0; i < 7; i++) do_op(tv[i]);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    all_zero("clr_done");
    sw_data = 8'h5A;
    for (int i = 0; i < 10; i++) begin
      btn_step = ~btn_step;
      repeat (2) @(negedge clk);
    end
    chk("bounce_no_step", 32'(state_o), 0);
    press(10, 10);
    chk("bounce_one_step", 32'(state_o), 1);
    chk("bounce_op_a", 32'(op_a), 32'h5A);
    sw_data = 8'h11;
    sw_mode = 1'b1;
    sw_cin = 1'b0;
    press(10, 10);
    chk("bounce_b_state", 32'(state_o), 3);
    chk("bounce_result", 32'(result_q), 32'h6B);
    sw_data = 8'h22;
    btn_step = 1'b1;
    repeat (100) @(negedge clk);
    chk("held_state", 32'(state_o), 1);
    chk("held_op_a", 32'(op_a), 32'h22);
    chk("held_done", 32'(done), 0);
    btn_step = 1'b0;
    repeat (10) @(negedge clk);
    chk("held_release_state", 32'(state_o), 1);
    clr = 1'b1;
    btn_step = 1'b1;
    repeat (12) @(negedge clk);
    clr = 1'b0;
    btn_step = 1'b0;
    repeat (10) @(negedge clk);
    all_zero("clr_step");
    do_op(tv[0]);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", 32'(state_o), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/addsub_step_ctrl.md
Name: addsub_step_ctrl

Overview:
- Sequential operand-entry front end that sits directly upstream of the 8-bit combinational add/sub stage.
- Debounces a single step button and walks a 4-state FSM that captures A from the switches, then B with mode E and carry/borrow-in C0.
- Drives the registered operands into the add/sub stage, samples its Result/C one cycle later, and holds them for the display stage.

Parameters:
- WIDTH, 8, operand/result width; must match the add/sub stage.
- DEBOUNCE_CYCLES, 20000, consecutive stable cycles needed to accept a button level change; must be >= 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sw_data  input  WIDTH  operand switches.
- sw_mode  input  1  E: 1 = add, 0 = subtract.
- sw_cin  input  1  C0 (carry-in for add, borrow-in for subtract).
- btn_step  input  1  raw, bouncy, asynchronous step button.
- clr  input  1  synchronous clear; returns the FSM to IDLE.
- op_a  output  WIDTH  registered A to the add/sub stage.
- op_b  output  WIDTH  registered B to the add/sub stage.
- op_e  output  1  registered E to the add/sub stage.
- op_c0  output  1  registered C0 to the add/sub stage.
- res_in  input  WIDTH  Result from the add/sub stage.
- c_in  input  1  C (carry or borrow) from the add/sub stage.
- result_q  output  WIDTH  latched result.
- carry_q  output  1  latched carry/borrow.
- ovf_q  output  1  signed overflow flag (see Optional Feature).
- done  output  1  high while result_q is valid.
- state_o  output  2  current FSM state, for LED display.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0; state IDLE; debouncer counter 0 with stable level 0.
- Input synchronisation and debounce:
  - btn_step passes through a 2-FF synchroniser.
  - The debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any mismatch-free cycle resets the counter.
  - step is a single-cycle pulse on the debounced rising edge. Exactly one pulse is produced per press; holding the button produces no repeats.
- FSM (state_o encoding: IDLE=0, GOT_A=1, EXEC=2, DONE=3):
  - IDLE: on step, op_a <= sw_data; go to GOT_A.
  - GOT_A: on step, op_b <= sw_data, op_e <= sw_mode, op_c0 <= sw_cin; go to EXEC.
  - EXEC: unconditional single cycle. result_q <= res_in, carry_q <= c_in, ovf_q updated; go to DONE. A step arriving in EXEC is dropped.
  - DONE: done = 1. On step, op_a <= sw_data, done <= 0; go to GOT_A. This chains a new operation.
- Latency:
  - The add/sub stage is combinational and fed from registers, so res_in is settled during EXEC.
  - Result is visible one cycle after the B-capture step, i.e. 2 clk after the second step pulse.
- clr:
  - Returns the FSM to IDLE and zeros op_*, result_q, carry_q, ovf_q and done.
  - clr and step in the same cycle: clr wins and the step is discarded.
- Operands and outputs:
  - op_* and result_q are held stable in every state except the captures above.
  - No arithmetic is performed in this block; widths pass through unchanged.
- Reset mid-operation:
  - Returns immediately to IDLE with all outputs 0, regardless of state.

Optional Feature:
- Macro ADDSUB_OVF_FLAG_EN.
- Defined: ovf_q is latched in EXEC as signed overflow.
  - Add (op_e=1): op_a[MSB]==op_b[MSB] && res_in[MSB]!=op_a[MSB].
  - Subtract (op_e=0): op_a[MSB]!=op_b[MSB] && res_in[MSB]!=op_a[MSB].
- Undefined: ovf_q is tied to 0. The port remains present in both builds.

Decomposition:
- Package addsub_ctrl_pkg:
  - state encoding constants S_IDLE..S_DONE.
  - state width (2).
  - default WIDTH.
- Sub-module btn_debounce:
  - Contains the synchroniser, counter and rising-edge pulse.
  - Parameterised by DEBOUNCE_CYCLES.
  - Ports: clk, rst_n, btn_raw, level, rise_pulse.
- Top level:
  - Holds the FSM and registers.
  - The bench connects it to the existing add/sub stage.

Test Plan (DEBOUNCE_CYCLES=4):
- Add with carry-out: sw_data=0xFF press, then sw_data=0x01, E=1, C0=0 press -> state IDLE->GOT_A->EXEC->DONE; result_q=0x00, carry_q=1, done=1.
- Subtract with borrow: A=0x03, B=0x05, E=0, C0=0 -> result_q=0xFE, carry_q=1. Then A=0x05, B=0x03 -> result_q=0x02, carry_q=0.
- Bounce rejection: btn toggling every 2 cycles for 20 cycles, then held high 10 cycles -> exactly one step pulse; op_a captured once.
- Held button: btn high for 100 cycles -> one pulse only; FSM advances exactly one state.
- clr and step together while in GOT_A -> state IDLE, all outputs 0. Async rst_n pulse during DONE -> all outputs 0 within the same cycle.
- ADDSUB_OVF_FLAG_EN defined: A=0x7F + B=0x01, E=1 -> result_q=0x80, ovf_q=1. Undefined: ovf_q=0.
